// File: rtl/bf16_accumulator.sv
// bf16_accumulator: streaming BF16 group sum with guard-bit accumulator and registered pack stage.
// Define BF16_ACC_ROUND_EN for round-to-nearest-even packing; otherwise guard bits are truncated.
module bf16_accumulator #(
   parameter int ACC_MANT_W = 16,
   parameter int CNT_W      = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   input  logic             clear,
   output logic             out_valid,
   output logic [15:0]      out_data,
   output logic [CNT_W-1:0] out_count,
   output logic [2:0]       out_flags
);
   localparam int W = ACC_MANT_W;
   localparam int LZW = $clog2(W + 1);
`ifdef BF16_ACC_ROUND_EN
   localparam int FW = W - 1;
`else
   localparam int FW = 7;
`endif
   typedef enum logic {IDLE, ACCUM} state_t;
   state_t state_q;
   logic sign_q, zero_q, nan_q, inf_q, sat_q;
   logic [7:0] exp_q;
   logic [W-1:0] man_q;
   logic [CNT_W-1:0] cnt_q;
   logic f_v_q, f_sign_q, f_zero_q, f_nan_q, f_inf_q, f_sat_q;
   logic [7:0] f_exp_q;
   logic [FW-1:0] f_man_q;
   logic [CNT_W-1:0] f_cnt_q;
   logic out_valid_q;
   logic [15:0] out_data_q;
   logic [CNT_W-1:0] out_count_q;
   logic [2:0] out_flags_q;
   logic in_sign, in_special, in_nan, in_inf, b_zero, start, a_zero, a_nan, a_inf;
   logic [7:0] in_exp, a_e, b_e, big_e, sm_e, diff;
   logic [6:0] in_frac;
   logic [W-1:0] a_m, b_m, big_m, sm_m, sh_m, n_man;
   logic a_big, big_s, sm_s, cnt_max, close;
   logic [W:0] sum;
   logic [LZW-1:0] lz;
   logic [10:0] n_exp;
   logic sign_d, zero_d, nan_d, inf_d, sat_d, ovf;
   logic [7:0] exp_d, p_e;
   logic [6:0] p_f;
   logic [CNT_W-1:0] cnt_d;
   logic p_inf;
   logic [15:0] data_d;
   logic [2:0] flags_d;
   assign in_sign    = in_data[15];
   assign in_exp     = in_data[14:7];
   assign in_frac    = in_data[6:0];
   assign in_special = in_exp == 8'hFF;
   assign in_nan     = in_special & (|in_frac);
   assign in_inf     = in_special & ~(|in_frac);
   assign b_zero     = (in_exp == 8'h00) | in_special;
   assign start      = state_q == IDLE;
   assign a_zero     = start | zero_q;
   assign a_nan      = ~start & nan_q;
   assign a_inf      = ~start & inf_q;
   assign a_e   = a_zero ? 8'h00 : exp_q;
   assign a_m   = a_zero ? '0 : man_q;
   assign b_e   = b_zero ? 8'h00 : in_exp;
   assign b_m   = b_zero ? '0 : {1'b1, in_frac, {(W-8){1'b0}}};
   assign a_big = {a_e, a_m} >= {b_e, b_m};
   assign big_e = a_big ? a_e : b_e;
   assign big_m = a_big ? a_m : b_m;
   assign big_s = a_big ? sign_q : in_sign;
   assign sm_e  = a_big ? b_e : a_e;
   assign sm_m  = a_big ? b_m : a_m;
   assign sm_s  = a_big ? in_sign : sign_q;
   assign diff  = big_e - sm_e;
   assign sh_m  = (32'(diff) >= W) ? '0 : sm_m >> diff;
   assign sum   = (big_s == sm_s) ? {1'b0, big_m} + {1'b0, sh_m} : {1'b0, big_m} - {1'b0, sh_m};
   always_comb begin
      lz = LZW'(W);
      for (int i = 0; i < W; i++) if (sum[i]) lz = LZW'(W - 1 - i);
   end
   // Exponent kept 11 bits wide so underflow after the left shift shows up as bit 10.
   assign n_man   = sum[W] ? sum[W:1] : sum[W-1:0] << lz;
   assign n_exp   = sum[W] ? 11'(big_e) + 11'd1 : 11'(big_e) - 11'(lz);
   assign zero_d  = (sum == '0) | n_exp[10] | (n_exp == 11'd0);
   assign ovf     = ~zero_d & (n_exp >= 11'd255);
   assign exp_d   = zero_d ? 8'h00 : n_exp[7:0];
   assign nan_d   = a_nan | in_nan | (a_inf & in_inf & (sign_q != in_sign));
   assign inf_d   = ~nan_d & (a_inf | in_inf | ovf);
   assign sign_d  = a_inf ? sign_q : in_inf ? in_sign : big_s;
   assign cnt_max = cnt_q == '1;
   assign cnt_d   = start ? CNT_W'(1) : cnt_max ? cnt_q : cnt_q + 1'b1;
   assign sat_d   = ~start & (sat_q | cnt_max);
   assign close   = in_valid & in_last & ~clear;
`ifdef BF16_ACC_ROUND_EN
   logic [W-8:0] ext;
   logic rnd;
   logic [8:0] p_m;
   assign ext = {f_man_q[W-9:0], 1'b0};
   assign rnd = ext[W-8] & ((|ext[W-9:0]) | f_man_q[W-8]);
   assign p_m = {2'b01, f_man_q[FW-1 -: 7]} + {8'd0, rnd};
   assign p_e = f_exp_q + {7'd0, p_m[8]};
   assign p_f = p_m[8] ? 7'd0 : p_m[6:0];
`else
   assign p_e = f_exp_q;
   assign p_f = f_man_q;
`endif
   assign p_inf   = f_inf_q | (~f_zero_q & (p_e == 8'hFF));
   assign data_d  = f_nan_q ? 16'h7FC0 : p_inf ? {f_sign_q, 8'hFF, 7'h00} :
                    f_zero_q ? 16'h0000 : {f_sign_q, p_e, p_f};
   assign flags_d = {f_nan_q, ~f_nan_q & p_inf, f_sat_q};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         zero_q      <= 1'b1;
         nan_q       <= 1'b0;
         inf_q       <= 1'b0;
         sat_q       <= 1'b0;
         exp_q       <= '0;
         man_q       <= '0;
         cnt_q       <= '0;
         f_v_q       <= 1'b0;
         f_sign_q    <= 1'b0;
         f_zero_q    <= 1'b1;
         f_nan_q     <= 1'b0;
         f_inf_q     <= 1'b0;
         f_sat_q     <= 1'b0;
         f_exp_q     <= '0;
         f_man_q     <= '0;
         f_cnt_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_flags_q <= '0;
      end else begin
         if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else if (in_valid) begin
            state_q <= in_last ? IDLE : ACCUM;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
            sat_q   <= sat_d;
            exp_q   <= exp_d;
            man_q   <= n_man;
            cnt_q   <= cnt_d;
         end
         f_v_q <= close;
         if (close) begin
            f_sign_q <= sign_d;
            f_zero_q <= zero_d;
            f_nan_q  <= nan_d;
            f_inf_q  <= inf_d;
            f_sat_q  <= sat_d;
            f_exp_q  <= exp_d;
            f_man_q  <= n_man[W-2 -: FW];
            f_cnt_q  <= cnt_d;
         end
         out_valid_q <= f_v_q;
         if (f_v_q) begin
            out_data_q  <= data_d;
            out_count_q <= f_cnt_q;
            out_flags_q <= flags_d;
         end
      end
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_flags = out_flags_q;
endmodule
